// File: rtl/hack_pkg.sv
// Shared definitions for the Hack memory-mapped keyboard: bus address,
// key codes, FSM state types and the byte/CSI-to-key translation helpers.
package hack_pkg;

  localparam logic [14:0] KBD_ADDR = 15'h6000;

  localparam logic [7:0] KEY_NEWLINE   = 8'd128;
  localparam logic [7:0] KEY_BACKSPACE = 8'd129;
  localparam logic [7:0] KEY_LEFT      = 8'd130;
  localparam logic [7:0] KEY_UP        = 8'd131;
  localparam logic [7:0] KEY_RIGHT     = 8'd132;
  localparam logic [7:0] KEY_DOWN      = 8'd133;
  localparam logic [7:0] KEY_HOME      = 8'd134;
  localparam logic [7:0] KEY_END       = 8'd135;
  localparam logic [7:0] KEY_ESC       = 8'd140;

  localparam logic [7:0] ASCII_ESC = 8'h1B;
  localparam logic [7:0] ASCII_LBR = 8'h5B;

  // BRK is only entered when the stop-bit check is compiled in.
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} rx_state_t;
  typedef enum logic [1:0] {E_IDLE, E_ESC, E_CSI} esc_state_t;

  // Plain byte to key code; 0 means the byte produces no key.
  function automatic logic [7:0] map_byte(input logic [7:0] b);
    if (b == 8'h0D || b == 8'h0A)      return KEY_NEWLINE;
    else if (b == 8'h08 || b == 8'h7F) return KEY_BACKSPACE;
    else if (b >= 8'h20 && b <= 8'h7E) return b;
    else                               return 8'h00;
  endfunction

  // Final byte of an ESC '[' sequence to key code; 0 means ignored.
  function automatic logic [7:0] csi_code(input logic [7:0] b);
    case (b)
      8'h41:   return KEY_UP;
      8'h42:   return KEY_DOWN;
      8'h43:   return KEY_RIGHT;
      8'h44:   return KEY_LEFT;
      8'h48:   return KEY_HOME;
      8'h46:   return KEY_END;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/uart_keyboard_rx.sv
// 8N1 UART receiver with 2-flop input synchroniser.
// Optional UART_KBD_FRAME_CHECK_EN: a low stop bit drops the byte and the
// receiver waits for the line to go idle (high) before hunting a new start.
module uart_rx
  import hack_pkg::*;
#(
  parameter int DIV = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 2;

  logic          rx_m, rx_s;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    shreg;

  // Bring the asynchronous line into the clk domain; idle level is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Frame receiver: centre the start bit, then sample each bit one DIV apart.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bitn       <= '0;
      shreg      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt  <= '0;
          bitn <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == CW'(DIV / 2 - 1)) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            bitn  <= bitn + 3'd1;
            if (bitn == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
`ifdef UART_KBD_FRAME_CHECK_EN
            if (rx_s) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
              state      <= IDLE;
            end else begin
              state <= BRK;
            end
`else
            byte_valid <= 1'b1;
            byte_data  <= shreg;
            state      <= IDLE;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BRK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_keyboard.sv
// Hack keyboard register at 0x6000 fed from a UART line. Decodes ASCII and
// ANSI cursor sequences, holds each key for HOLD_CYCLES, then releases it.
// Build option UART_KBD_FRAME_CHECK_EN enables stop-bit checking in uart_rx.
module uart_keyboard
  import hack_pkg::*;
#(
  parameter int CLK_HZ      = 12000000,
  parameter int BAUD        = 115200,
  parameter int HOLD_CYCLES = 1200000,
  parameter int ESC_CYCLES  = 24000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  input  logic [14:0] address,
  output logic [15:0] out,
  output logic        hit
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HW  = $clog2(HOLD_CYCLES + 1);
  localparam int EW  = $clog2(ESC_CYCLES + 1);

  logic [7:0]    rx_byte;
  logic          rx_vld;
  esc_state_t    esc_state;
  logic [EW-1:0] esc_tmr;
  logic [HW-1:0] hold;
  logic [7:0]    key;
  logic          emit;
  logic [7:0]    emit_code;

  uart_rx #(.DIV(DIV)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .byte_data  (rx_byte),
    .byte_valid (rx_vld)
  );

  // Decide whether this cycle produces a key and which one.
  always_comb begin
    emit      = 1'b0;
    emit_code = 8'h00;
    case (esc_state)
      E_IDLE: begin
        if (rx_vld && rx_byte != ASCII_ESC) begin
          emit_code = map_byte(rx_byte);
          emit      = (emit_code != 8'h00);
        end
      end
      E_ESC: begin
        if (rx_vld) begin
          if (rx_byte != ASCII_LBR) begin
            emit      = 1'b1;
            emit_code = KEY_ESC;
          end
        end else if (esc_tmr == '0) begin
          emit      = 1'b1;
          emit_code = KEY_ESC;
        end
      end
      E_CSI: begin
        if (rx_vld) begin
          emit_code = csi_code(rx_byte);
          emit      = (emit_code != 8'h00);
        end
      end
      default: ;
    endcase
  end

  // Escape-sequence state, key register and hold timer; a new key beats expiry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      esc_state <= E_IDLE;
      esc_tmr   <= '0;
      key       <= '0;
      hold      <= '0;
    end else begin
      case (esc_state)
        E_IDLE: begin
          if (rx_vld && rx_byte == ASCII_ESC) begin
            esc_state <= E_ESC;
            esc_tmr   <= EW'(ESC_CYCLES);
          end
        end
        E_ESC: begin
          if (rx_vld) esc_state <= (rx_byte == ASCII_LBR) ? E_CSI : E_IDLE;
          else if (esc_tmr == '0) esc_state <= E_IDLE;
          else esc_tmr <= esc_tmr - EW'(1);
        end
        E_CSI: begin
          if (rx_vld) esc_state <= E_IDLE;
        end
        default: esc_state <= E_IDLE;
      endcase

      if (emit) begin
        key  <= emit_code;
        hold <= HW'(HOLD_CYCLES);
      end else if (hold != '0) begin
        hold <= hold - HW'(1);
        if (hold == HW'(1)) key <= '0;
      end
    end
  end

  // Registered read port, one cycle of latency like the neighbouring RAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out <= '0;
      hit <= 1'b0;
    end else begin
      out <= {8'h00, key};
      hit <= (address == KBD_ADDR);
    end
  end

endmodule

// File: tb/tb_uart_keyboard.sv
// Scoreboard bench for uart_keyboard: directed and random UART traffic.
`timescale 1ns/1ps
module tb_uart_keyboard;

  localparam int CLK_HZ = 5200000;
  localparam int BAUD   = 100000;
  localparam int HOLD   = 600;
  localparam int ESCC   = 600;
  localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
  localparam logic [14:0] KADDR = 15'h6000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [14:0] address = KADDR;
  logic [15:0] out;
  logic        hit;

  uart_keyboard #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .HOLD_CYCLES(HOLD), .ESC_CYCLES(ESCC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .address(address), .out(out), .hit(hit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] code;
    int         lo;
    int         hi;
  } exp_t;

  exp_t expq[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 1'b0;

  // ---------------- reference model ----------------
  function automatic logic [8:0] ascii_key(input logic [7:0] b);
    if (b == 8'h0D || b == 8'h0A) return {1'b1, 8'd128};
    if (b == 8'h08 || b == 8'h7F) return {1'b1, 8'd129};
    if (b >= 8'h20 && b <= 8'h7E) return {1'b1, b};
    return 9'h000;
  endfunction

  function automatic logic [8:0] csi_key(input logic [7:0] b);
    logic [7:0] finals [6] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h48, 8'h46};
    logic [7:0] codes  [6] = '{8'd131, 8'd133, 8'd132, 8'd130, 8'd134, 8'd135};
    for (int i = 0; i < 6; i++)
      if (finals[i] == b) return {1'b1, codes[i]};
    return 9'h000;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] code, input int c);
    exp_t e;
    e.code = code;
    e.lo   = c;
    e.hi   = c + 10;
    expq.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(DIV);
    end
    if (good_stop) begin
      rx = 1'b1;
      tick(DIV);
    end else begin
      rx = 1'b0;
      tick(DIV / 2 + 4);
      rx = 1'b1;
      tick(DIV);
    end
  endtask

  // Back-to-back bytes; emit_idx < 0 means no key is expected.
  task automatic send_seq(input int n, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input int emit_idx,
                          input logic [7:0] code, input int extra);
    if (emit_idx >= 0)
      push(code, cyc + emit_idx * 10 * DIV + 9 * DIV + DIV / 2 + extra);
    send_byte(b0, 1'b1);
    if (n > 1) send_byte(b1, 1'b1);
    if (n > 2) send_byte(b2, 1'b1);
    if (emit_idx >= 0) tick(HOLD + ESCC + 64);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    logic [8:0] r;
    logic [7:0] fin [7] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h48, 8'h46, 8'h00};
    int c;
    tick(5);
    rst_n = 1'b1;
    tick(5);

    send_seq(1, 8'h61, 8'h00, 8'h00, 0, 8'h61, 0);
    send_seq(3, 8'h1B, 8'h5B, 8'h41, 2, 8'd131, 0);
    send_seq(1, 8'h1B, 8'h00, 8'h00, 0, 8'd140, ESCC);
    send_seq(1, 8'h0D, 8'h00, 8'h00, 0, 8'd128, 0);
    send_seq(1, 8'h7F, 8'h00, 8'h00, 0, 8'd129, 0);
    send_seq(1, 8'h01, 8'h00, 8'h00, -1, 8'h00, 0);
    send_seq(2, 8'h1B, 8'h78, 8'h00, 1, 8'd140, 0);
    send_seq(3, 8'h1B, 8'h5B, 8'h48, 2, 8'd134, 0);
    send_seq(3, 8'h1B, 8'h5B, 8'h46, 2, 8'd135, 0);
    send_seq(3, 8'h1B, 8'h5B, 8'h5A, -1, 8'h00, 0);

    // 'a' then 'b' while 'a' is still held: replace and reload
    c = cyc + 9 * DIV + DIV / 2;
    push(8'h61, c);
    push(8'h62, c + 10 * DIV);
    send_byte(8'h61, 1'b1);
    send_byte(8'h62, 1'b1);
    tick(HOLD + ESCC + 64);

    // short low glitch must not start a frame
    rx = 1'b0;
    tick(20);
    rx = 1'b1;
    tick(3 * DIV);

    // stop bit driven low
`ifndef UART_KBD_FRAME_CHECK_EN
    push(8'h61, cyc + 9 * DIV + DIV / 2);
`endif
    send_byte(8'h61, 1'b0);
    tick(HOLD + ESCC + 64);

    // reset during data bit 4, then a clean byte
    b = 8'h61;
    rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      tick(DIV);
    end
    rx = b[4];
    tick(DIV / 2);
    rst_n = 1'b0;
    rx = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2 * DIV);
    send_seq(1, 8'h7A, 8'h00, 8'h00, 0, 8'h7A, 0);

    // random items
    for (int k = 0; k < 10; k++) begin
      b = 8'($urandom);
      case ($urandom % 4)
        0: begin
          if (b == 8'h1B) b = 8'h20;
          r = ascii_key(b);
          if (r[8]) send_seq(1, b, 8'h00, 8'h00, 0, r[7:0], 0);
          else      send_seq(1, b, 8'h00, 8'h00, -1, 8'h00, 0);
        end
        1: send_seq(1, 8'h1B, 8'h00, 8'h00, 0, 8'd140, ESCC);
        2: begin
          if (b == 8'h5B) b = 8'h41;
          send_seq(2, 8'h1B, b, 8'h00, 1, 8'd140, 0);
        end
        default: begin
          fin[6] = b;
          b = fin[$urandom % 7];
          r = csi_key(b);
          if (r[8]) send_seq(3, 8'h1B, 8'h5B, b, 2, r[7:0], 0);
          else      send_seq(3, 8'h1B, 8'h5B, b, -1, 8'h00, 0);
        end
      endcase
    end

    tick(10);
    done = 1'b1;
  end

  // Bus address wanders, mostly resting on the keyboard address.
  initial begin
    forever begin
      repeat (37) @(posedge clk);
      #1;
      address = ($urandom % 4 != 0) ? KADDR : 15'($urandom);
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, got cyc=%0d required done", cyc);
    $fatal(1);
  end

  // ---------------- monitor / scoreboard ----------------
  logic        rst_q = 1'b0;
  logic [14:0] addr_q = '0;
  logic [15:0] prev_out = '0;
  int          load_cyc = -1;
  exp_t        e_m;

  always @(posedge clk) begin
    rst_q  <= rst_n;
    addr_q <= address;
  end

  always @(negedge clk) begin
    vectors++;
    if (hit !== (rst_q && addr_q == KADDR)) begin
      miscompares++;
      $display("FAIL hit cyc=%0d got %b required %b", cyc, hit, (rst_q && addr_q == KADDR));
    end
    if (!rst_q) begin
      vectors++;
      if (out !== 16'h0000) begin
        miscompares++;
        $display("FAIL reset_out cyc=%0d got %h required 0000", cyc, out);
      end
      prev_out = 16'h0000;
      load_cyc = -1;
    end else if (out !== prev_out) begin
      if (out != 16'h0000) begin
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_key cyc=%0d got %h required no change", cyc, out);
        end else begin
          e_m = expq.pop_front();
          if (out !== {8'h00, e_m.code}) begin
            miscompares++;
            $display("FAIL key_code cyc=%0d got %h required %h", cyc, out, {8'h00, e_m.code});
          end
          vectors++;
          if (cyc < e_m.lo || cyc > e_m.hi) begin
            miscompares++;
            $display("FAIL key_time got cyc=%0d required %0d..%0d", cyc, e_m.lo, e_m.hi);
          end
        end
        load_cyc = cyc;
      end else begin
        vectors++;
        if (load_cyc < 0 || cyc - load_cyc != HOLD) begin
          miscompares++;
          $display("FAIL release got %0d cycles held required %0d", cyc - load_cyc, HOLD);
        end
      end
      prev_out = out;
    end
    if (done) begin
      vectors++;
      if (expq.size() != 0) begin
        miscompares++;
        $display("FAIL missing_keys got %0d pending required 0", expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

endmodule
